// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch widths, prefetch depth and the {pc, instr} entry type
package fetch_pkg;
  localparam int FETCH_ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam int PREFETCH_DEPTH = 4;
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: show-ahead circular FIFO of {pc, instr} between fetch and decode, flushed on redirect
module instr_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = PREFETCH_DEPTH,
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = INSTR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_valid,
  input  logic [ADDR_W-1:0]          fetch_pc,
  input  logic [DATA_W-1:0]          fetch_instr,
  output logic                       fetch_ready,
  output logic                       instruction_valid,
  output logic [DATA_W-1:0]          instr_out,
  output logic [ADDR_W-1:0]          pc_out,
  input  logic                       decode_ready,
  input  logic                       flush,
  output logic                       prefetch_full,
  output logic                       prefetch_empty,
  output logic                       stall,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  fetch_entry_t mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop;
  always_comb begin
    prefetch_full = count_q == CW'(DEPTH);
    prefetch_empty = count_q == '0;
    fetch_ready = !prefetch_full;
    instruction_valid = !prefetch_empty;
    stall = fetch_valid && !fetch_ready;
    push = fetch_valid && fetch_ready;
    pop = instruction_valid && decode_ready;
    instr_out = mem_q[rd_ptr_q].instr;
    pc_out = mem_q[rd_ptr_q].pc;
    count = count_q;
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem_q[wr_ptr_q] <= '{pc: fetch_pc, instr: fetch_instr};
  end
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && prefetch_full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && prefetch_empty));
  a_count_max: assert property (@(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));
  a_full_empty: assert property (@(posedge clk) disable iff (rst) !(prefetch_full && prefetch_empty));
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb_instr_prefetch_buffer: table-driven directed checks of the prefetch FIFO
module tb_instr_prefetch_buffer;
  import fetch_pkg::*;
  logic clk = 0;
  logic rst, fetch_valid, fetch_ready, instruction_valid, decode_ready, flush;
  logic prefetch_full, prefetch_empty, stall;
  logic [31:0] fetch_pc, fetch_instr, instr_out, pc_out;
  logic [2:0] count;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic rs, fl, fv, dr;
    logic [31:0] pc;
    logic [2:0] cnt;
    logic [31:0] hpc;
    logic stl;
  } vec_t;
  vec_t vq[$];
  instr_prefetch_buffer dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr), .fetch_ready(fetch_ready),
    .instruction_valid(instruction_valid), .instr_out(instr_out), .pc_out(pc_out),
    .decode_ready(decode_ready), .flush(flush), .prefetch_full(prefetch_full),
    .prefetch_empty(prefetch_empty), .stall(stall), .count(count)
  );
  always #5 clk = ~clk;
  function automatic void add(logic rs, logic fl, logic fv, logic dr, logic [31:0] pc,
                              logic [2:0] cnt, logic [31:0] hpc, logic stl);
    vec_t v;
    v.rs = rs; v.fl = fl; v.fv = fv; v.dr = dr; v.pc = pc;
    v.cnt = cnt; v.hpc = hpc; v.stl = stl;
    vq.push_back(v);
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    rst = 1; flush = 0; fetch_valid = 0; decode_ready = 0; fetch_pc = 0; fetch_instr = 0;
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 32'h0, 1, 32'h0, 0);
    add(0, 0, 1, 0, 32'h4, 2, 32'h0, 0);
    add(0, 0, 1, 0, 32'h8, 3, 32'h0, 0);
    add(0, 0, 1, 0, 32'hC, 4, 32'h0, 1);
    add(0, 0, 1, 0, 32'h10, 4, 32'h0, 1);
    add(0, 0, 0, 1, 0, 3, 32'h4, 0);
    add(0, 0, 0, 1, 0, 2, 32'h8, 0);
    add(0, 0, 0, 1, 0, 1, 32'hC, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 32'h20, 1, 32'h20, 0);
    add(0, 0, 1, 0, 32'h24, 2, 32'h20, 0);
    for (int k = 0; k < 10; k++) add(0, 0, 1, 1, 32'h28 + 4 * k, 2, 32'h24 + 4 * k, 0);
    add(0, 0, 1, 0, 32'h50, 3, 32'h48, 0);
    add(0, 1, 1, 0, 32'h100, 0, 0, 0);
    add(0, 0, 1, 0, 32'h200, 1, 32'h200, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 32'h300, 1, 32'h300, 0);
    add(0, 0, 1, 0, 32'h304, 2, 32'h300, 0);
    add(0, 0, 1, 0, 32'h308, 3, 32'h300, 0);
    add(0, 0, 1, 0, 32'h30C, 4, 32'h300, 1);
    add(0, 0, 1, 1, 32'h310, 3, 32'h304, 0);
    add(0, 0, 1, 0, 32'h314, 4, 32'h304, 1);
    add(1, 0, 1, 0, 32'h318, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    foreach (vq[i]) begin
      rst = vq[i].rs; flush = vq[i].fl; fetch_valid = vq[i].fv; decode_ready = vq[i].dr;
      fetch_pc = vq[i].pc; fetch_instr = ~vq[i].pc;
      @(posedge clk); #1;
      chk($sformatf("v%0d count", i), 32'(count), 32'(vq[i].cnt));
      chk($sformatf("v%0d empty", i), 32'(prefetch_empty), 32'(vq[i].cnt == 0));
      chk($sformatf("v%0d full", i), 32'(prefetch_full), 32'(vq[i].cnt == 4));
      chk($sformatf("v%0d valid", i), 32'(instruction_valid), 32'(vq[i].cnt != 0));
      chk($sformatf("v%0d ready", i), 32'(fetch_ready), 32'(vq[i].cnt != 4));
      chk($sformatf("v%0d stall", i), 32'(stall), 32'(vq[i].stl));
      if (vq[i].cnt != 0) begin
        chk($sformatf("v%0d pc_out", i), pc_out, vq[i].hpc);
        chk($sformatf("v%0d instr_out", i), instr_out, ~vq[i].hpc);
      end
    end
    for (int k = 0; k < 4; k++) begin
      fetch_valid = 1; decode_ready = 0; fetch_pc = 32'h400 + 4 * k; fetch_instr = 32'hA0 + k;
      @(posedge clk); #1;
    end
    fetch_valid = 0; #1;
    chk("stall_comb_low", 32'(stall), 0);
    fetch_valid = 1; #1;
    chk("stall_comb_high", 32'(stall), 1);
    decode_ready = 1; #1;
    chk("stall_no_pop_relief", 32'(stall), 1);
    flush = 1;
    @(posedge clk); #1;
    flush = 0; fetch_valid = 0; decode_ready = 0;
    chk("flush_pop_count", 32'(count), 0);
    chk("flush_ready", 32'(fetch_ready), 1);
    fetch_valid = 1; fetch_pc = 32'h500; fetch_instr = 32'h55;
    @(posedge clk); #1;
    fetch_valid = 0;
    chk("after_flush_head_pc", pc_out, 32'h500);
    chk("after_flush_head_instr", instr_out, 32'h55);
    chk("after_flush_count", 32'(count), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
